// File: rtl/id_stage_pipe.sv
// Decode stage for the OpenMIPS logic/shift subset with an integrated ID/EX register.
// Resolves operands through EX/MEM forwarding and requests a stall on load-use hazards.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       inst_i,
    input  logic              inst_valid_i,
    output logic [REG_AW-1:0] reg1_addr_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              ex_valid_o,
    output logic [31:0]       ex_pc_o,
    output logic [7:0]        ex_aluop_o,
    output logic [2:0]        ex_alusel_o,
    output logic [DATA_W-1:0] ex_reg1_o,
    output logic [DATA_W-1:0] ex_reg2_o,
    output logic [REG_AW-1:0] ex_wd_o,
    output logic              ex_wreg_o,
    output logic              ex_inst_invalid_o,
    output logic [STAT_W-1:0] stat_stall_cnt_o
);

    localparam logic [7:0] EXE_NOP_OP    = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP    = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP     = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP    = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP    = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP    = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP    = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP    = 8'b0000_0011;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    // A zeroed slot is exactly a bubble because the NOP codes are all zero.
    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [7:0]        aluop;
        logic [2:0]        alusel;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [REG_AW-1:0] wd;
        logic              wreg;
        logic              invalid;
    } slot_t;

    logic [5:0]        op, funct;
    logic [REG_AW-1:0] rs, rt, rd, r1_addr;
    logic              rd1, rd2;
    logic [DATA_W-1:0] imm1, imm2;
    slot_t             dec, slot;
    logic [STAT_W-1:0] stall_cnt;

    assign op    = inst_i[31:26];
    assign funct = inst_i[5:0];
    assign rs    = REG_AW'(inst_i[25:21]);
    assign rt    = REG_AW'(inst_i[20:16]);
    assign rd    = REG_AW'(inst_i[15:11]);

    function automatic logic [DATA_W-1:0] resolve(
        input logic              en,
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rdata,
        input logic [DATA_W-1:0] imm,
        input logic              exw,
        input logic [REG_AW-1:0] exd,
        input logic [DATA_W-1:0] exv,
        input logic              memw,
        input logic [REG_AW-1:0] memd,
        input logic [DATA_W-1:0] memv
    );
        if (!en)                                      return imm;
        else if (addr == '0)                          return '0;
        else if (FWD_EN != 0 && exw && exd == addr)   return exv;
        else if (FWD_EN != 0 && memw && memd == addr) return memv;
        else                                          return rdata;
    endfunction

    always_comb begin
        dec     = '0;
        r1_addr = rs;
        rd1     = 1'b0;
        rd2     = 1'b0;
        imm1    = '0;
        imm2    = '0;
        if (inst_valid_i) begin
            dec.valid = 1'b1;
            dec.pc    = pc_i;
            case (op)
                6'h0C, 6'h0D, 6'h0E: begin
                    dec.aluop  = (op == 6'h0C) ? EXE_AND_OP :
                                 (op == 6'h0D) ? EXE_OR_OP : EXE_XOR_OP;
                    dec.alusel = EXE_RES_LOGIC;
                    dec.wd     = rt;
                    dec.wreg   = 1'b1;
                    rd1        = 1'b1;
                    imm2       = DATA_W'(inst_i[15:0]);
                end
                6'h0F: begin
                    dec.aluop  = EXE_OR_OP;
                    dec.alusel = EXE_RES_LOGIC;
                    dec.wd     = rt;
                    dec.wreg   = 1'b1;
                    r1_addr    = '0;
                    rd1        = 1'b1;
                    imm2       = DATA_W'(inst_i[15:0]) << (DATA_W - 16);
                end
                6'h00: begin
                    case (funct)
                        6'h24, 6'h25, 6'h26, 6'h27: begin
                            dec.aluop  = (funct == 6'h24) ? EXE_AND_OP :
                                         (funct == 6'h25) ? EXE_OR_OP  :
                                         (funct == 6'h26) ? EXE_XOR_OP : EXE_NOR_OP;
                            dec.alusel = EXE_RES_LOGIC;
                            dec.wd     = rd;
                            dec.wreg   = 1'b1;
                            rd1        = 1'b1;
                            rd2        = 1'b1;
                        end
                        6'h00, 6'h02, 6'h03: begin
                            dec.aluop  = (funct == 6'h00) ? EXE_SLL_OP :
                                         (funct == 6'h02) ? EXE_SRL_OP : EXE_SRA_OP;
                            dec.alusel = EXE_RES_SHIFT;
                            dec.wd     = rd;
                            dec.wreg   = 1'b1;
                            rd2        = 1'b1;
                            imm1       = DATA_W'(inst_i[10:6]);
                        end
                        default: dec.invalid = 1'b1;
                    endcase
                end
                default: dec.invalid = 1'b1;
            endcase
        end
        dec.reg1 = resolve(rd1, r1_addr, reg1_data_i, imm1, ex_wreg_i, ex_wd_i, ex_wdata_i,
                           mem_wreg_i, mem_wd_i, mem_wdata_i);
        dec.reg2 = resolve(rd2, rt, reg2_data_i, imm2, ex_wreg_i, ex_wd_i, ex_wdata_i,
                           mem_wreg_i, mem_wd_i, mem_wdata_i);
    end

    assign reg1_addr_o = r1_addr;
    assign reg2_addr_o = rt;
    assign reg1_read_o = rd1;
    assign reg2_read_o = rd2;

    // Hazard is independent of FWD_EN: a load result is never available in ID.
    assign stall_req_o = inst_valid_i && ex_wreg_i && ex_is_load_i && (ex_wd_i != '0) &&
                         ((rd1 && ex_wd_i == r1_addr) || (rd2 && ex_wd_i == rt));

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot      <= '0;
            stall_cnt <= '0;
        end else if (flush_i) begin
            slot <= '0;
        end else if (stall_i) begin
            slot <= slot;
        end else if (stall_req_o) begin
            slot <= '0;
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end else begin
            slot <= dec;
        end
    end

    assign ex_valid_o        = slot.valid;
    assign ex_pc_o           = slot.pc;
    assign ex_aluop_o        = slot.aluop;
    assign ex_alusel_o       = slot.alusel;
    assign ex_reg1_o         = slot.reg1;
    assign ex_reg2_o         = slot.reg2;
    assign ex_wd_o           = slot.wd;
    assign ex_wreg_o         = slot.wreg;
    assign ex_inst_invalid_o = slot.invalid;
    assign stat_stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: the driver queues the expected ID/EX slot per cycle,
// a monitor pops and compares one cycle later.
module tb_id_stage_pipe;

    localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_SRA = 8'h03;
    localparam logic [2:0] RS_NOP = 3'd0, RS_LOGIC = 3'd1, RS_SHIFT = 3'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic        invalid;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i, inst_i;
    logic        inst_valid_i;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic        reg1_read_o, reg2_read_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        stall_i, flush_i, stall_req_o;
    logic        ex_valid_o, ex_wreg_o, ex_inst_invalid_o;
    logic [31:0] ex_pc_o, ex_reg1_o, ex_reg2_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [4:0]  ex_wd_o;
    logic [15:0] stat_stall_cnt_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .REG_AW(5), .FWD_EN(1), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
        .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .ex_inst_invalid_o(ex_inst_invalid_o), .stat_stall_cnt_o(stat_stall_cnt_o)
    );

    function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [7:0] aop,
                                input logic [2:0] asel, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] wd, input logic wr, input logic inv,
                                input logic [15:0] cnt);
        mk = '{valid: v, pc: pc, aluop: aop, alusel: asel, reg1: r1, reg2: r2,
               wd: wd, wreg: wr, invalid: inv, cnt: cnt};
    endfunction

    function automatic exp_t bubble(input logic [15:0] cnt);
        bubble = mk(1'b0, 32'h0, OP_NOP, RS_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, cnt);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: one expected slot per clock, compared just after the edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = mk(ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
                       ex_wd_o, ex_wreg_o, ex_inst_invalid_o, stat_stall_cnt_o);
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL slot @%0t: got v=%b pc=%h op=%h sel=%h r1=%h r2=%h wd=%0d wr=%b inv=%b cnt=%0d expected v=%b pc=%h op=%h sel=%h r1=%h r2=%h wd=%0d wr=%b inv=%b cnt=%0d",
                             $time, a.valid, a.pc, a.aluop, a.alusel, a.reg1, a.reg2, a.wd, a.wreg, a.invalid, a.cnt,
                             e.valid, e.pc, e.aluop, e.alusel, e.reg1, e.reg2, e.wd, e.wreg, e.invalid, e.cnt);
                end
            end
        end
    end

    task automatic idle();
        inst_valid_i = 0; inst_i = 0; pc_i = 0;
        reg1_data_i = 0; reg2_data_i = 0;
        ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
        mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
        stall_i = 0; flush_i = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
        pc_i = pc; inst_i = inst; inst_valid_i = 1;
    endtask

    // Queue the expectation for the coming edge, then advance to the next negedge.
    task automatic step(input exp_t e);
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        rst = 0;
        idle();
        @(negedge clk);

        // reset held two cycles
        #1 chk("reset_stall_req", {31'b0, stall_req_o}, 32'h0);
        step(bubble(16'd0));
        step(bubble(16'd0));
        rst = 1;

        // ori $3,$1,0x8001
        issue(32'h100, 32'h34238001); reg1_data_i = 32'h00001100;
        #1 chk("ori_addr1", {27'b0, reg1_addr_o}, 32'd1);
        chk("ori_reads", {30'b0, reg1_read_o, reg2_read_o}, 32'b10);
        step(mk(1, 32'h100, OP_OR, RS_LOGIC, 32'h00001100, 32'h00008001, 5'd3, 1, 0, 16'd0));

        // or $5,$1,$2: EX beats MEM on $1, $2 from regfile
        idle(); issue(32'h104, 32'h00222825);
        ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'hAAAA0000;
        mem_wreg_i = 1; mem_wd_i = 1; mem_wdata_i = 32'h11111111;
        reg1_data_i = 32'h99999999; reg2_data_i = 32'h22222222;
        step(mk(1, 32'h104, OP_OR, RS_LOGIC, 32'hAAAA0000, 32'h22222222, 5'd5, 1, 0, 16'd0));

        // or $5,$1,$2: EX to $1, MEM to $2
        mem_wd_i = 2; mem_wdata_i = 32'h0000BBBB; pc_i = 32'h108;
        step(mk(1, 32'h108, OP_OR, RS_LOGIC, 32'hAAAA0000, 32'h0000BBBB, 5'd5, 1, 0, 16'd0));

        // or $5,$0,$2 with EX writing $0
        idle(); issue(32'h10C, 32'h00022825);
        ex_wreg_i = 1; ex_wd_i = 0; ex_wdata_i = 32'hDEADBEEF;
        reg1_data_i = 32'h12345678; reg2_data_i = 32'h33333333;
        step(mk(1, 32'h10C, OP_OR, RS_LOGIC, 32'h0, 32'h33333333, 5'd5, 1, 0, 16'd0));

        // and $6,$4,$7 behind a load to $4
        idle(); issue(32'h110, 32'h00873024);
        ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1; ex_wdata_i = 32'h77777777;
        #1 chk("loaduse_stall_req", {31'b0, stall_req_o}, 32'h1);
        step(bubble(16'd1));
        ex_wreg_i = 0; ex_is_load_i = 0;
        mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'h0F0F0F0F; reg2_data_i = 32'h000000FF;
        #1 chk("loaduse_release", {31'b0, stall_req_o}, 32'h0);
        step(mk(1, 32'h110, OP_AND, RS_LOGIC, 32'h0F0F0F0F, 32'h000000FF, 5'd6, 1, 0, 16'd1));

        // flush and stall together
        idle(); issue(32'h114, 32'h34238001); flush_i = 1; stall_i = 1;
        step(bubble(16'd1));

        // lui $2,0xABCD (reg1 from $0 regardless of regfile data)
        idle(); issue(32'h118, 32'h3C02ABCD); reg1_data_i = 32'h55555555;
        #1 chk("lui_addr1", {27'b0, reg1_addr_o}, 32'd0);
        step(mk(1, 32'h118, OP_OR, RS_LOGIC, 32'h0, 32'hABCD0000, 5'd2, 1, 0, 16'd1));

        // stall_i holds for 3 cycles, including one with a pending load-use
        idle(); issue(32'h11C, 32'h00031083); stall_i = 1; reg2_data_i = 32'h80000000;
        step(mk(1, 32'h118, OP_OR, RS_LOGIC, 32'h0, 32'hABCD0000, 5'd2, 1, 0, 16'd1));
        ex_wreg_i = 1; ex_wd_i = 3; ex_is_load_i = 1;
        #1 chk("hold_stall_req", {31'b0, stall_req_o}, 32'h1);
        step(mk(1, 32'h118, OP_OR, RS_LOGIC, 32'h0, 32'hABCD0000, 5'd2, 1, 0, 16'd1));
        ex_wreg_i = 0; ex_is_load_i = 0;
        step(mk(1, 32'h118, OP_OR, RS_LOGIC, 32'h0, 32'hABCD0000, 5'd2, 1, 0, 16'd1));

        // sra $2,$3,2
        stall_i = 0;
        #1 chk("sra_reads", {30'b0, reg1_read_o, reg2_read_o}, 32'b01);
        chk("sra_addr2", {27'b0, reg2_addr_o}, 32'd3);
        step(mk(1, 32'h11C, OP_SRA, RS_SHIFT, 32'h2, 32'h80000000, 5'd2, 1, 0, 16'd1));

        // opcode 0x3F is not recognised
        idle(); issue(32'h120, 32'hFC000000); reg1_data_i = 32'h1; reg2_data_i = 32'h2;
        #1 chk("inv_reads", {30'b0, reg1_read_o, reg2_read_o}, 32'b00);
        step(mk(1, 32'h120, OP_NOP, RS_NOP, 32'h0, 32'h0, 5'd0, 0, 1, 16'd1));

        // bubble input never raises a hazard
        idle(); inst_i = 32'h00873024; ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1;
        #1 chk("bubble_no_stall", {31'b0, stall_req_o}, 32'h0);
        step(bubble(16'd1));

        // another load-use bumps the counter to 2
        idle(); issue(32'h124, 32'h00873024); ex_wreg_i = 1; ex_wd_i = 7; ex_is_load_i = 1;
        step(bubble(16'd2));

        // mid-stream reset drops the held instruction and the counter
        idle(); issue(32'h128, 32'h34238001); rst = 0;
        step(bubble(16'd0));
        rst = 1; reg1_data_i = 32'h00000042;
        step(mk(1, 32'h128, OP_OR, RS_LOGIC, 32'h42, 32'h00008001, 5'd3, 1, 0, 16'd0));

        idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
